// File: rtl/dmem_port_b_pkg.sv
// Shared definitions for the byte-addressed data memory port: FSM encoding,
// read request code and default parameter values.
package dmem_port_b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WEB_READ            = 4'b0000;
    localparam int         DEFAULT_DEPTH_WORDS = 1024;
    localparam int         DEFAULT_WAIT_CYCLES = 1;

    // True when a 30-bit word index addresses a stored word.
    function automatic logic word_in_range(input logic [29:0] idx, input int depth);
        return {2'b00, idx} < 32'(depth);
    endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Single-port synchronous RAM built from four byte-wide lanes, each with its
// own write enable and a registered read.
module dmem_bytelane_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (we[gi]) begin
                        mem[addr] <= wdata[gi*8 +: 8];
                    end
                    q_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_port_b.sv
// Load/store side of the data memory: accepts one request at a time, waits a
// fixed number of cycles, then returns a one-cycle registered response.
module dmem_port_b
    import dmem_port_b_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enb,
    input  logic [31:0] addrb,
    input  logic [3:0]  web,
    input  logic [31:0] dib,
    output logic        rdyb,
    output logic        ackb,
    output logic [31:0] dob,
    output logic        errb
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [29:0] addr_reg;
    logic [3:0]  web_reg;
    logic [31:0] dib_reg;
    logic        accept;

    logic [29:0] acc_idx;
    logic [3:0]  acc_web;
    logic [31:0] acc_dib;
    logic        ram_en;
    logic [31:0] ram_rdata;
    logic        resp_in_range;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^addrb[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            web_reg   <= WEB_READ;
            dib_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= addrb[31:2];
                web_reg  <= web;
                dib_reg  <= dib;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enb) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // With no wait cycles the RAM access coincides with acceptance, so the
    // request fields come straight from the inputs rather than the capture regs.
    always_comb begin
        if (state_reg == ST_IDLE) begin
            acc_idx = addrb[31:2];
            acc_web = web;
            acc_dib = dib;
        end else begin
            acc_idx = addr_reg;
            acc_web = web_reg;
            acc_dib = dib_reg;
        end
    end

    assign ram_en = !rst && (state_next == ST_RESP) && word_in_range(acc_idx, DEPTH_WORDS);

    dmem_bytelane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (acc_web),
        .addr (acc_idx[AW-1:0]),
        .wdata(acc_dib),
        .rdata(ram_rdata)
    );

    assign resp_in_range = word_in_range(addr_reg, DEPTH_WORDS);
    assign rdyb          = (state_reg == ST_IDLE);
    assign ackb          = (state_reg == ST_RESP);
    assign errb          = ackb && !resp_in_range;
    assign dob           = (ackb && resp_in_range && (web_reg == WEB_READ)) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_port_b.sv
// Bench for dmem_port_b: two instances (one and zero wait cycles) share the
// same stimulus and are compared every cycle against a request-level model.
module tb_dmem_port_b;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b0;
    logic [31:0] addrb = 32'd0;
    logic [3:0]  web = 4'd0;
    logic [31:0] dib = 32'd0;

    // index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=0
    logic        rdy_w [2];
    logic        ack_w [2];
    logic        err_w [2];
    logic [31:0] dob_w [2];

    always #5 clk = ~clk;

    dmem_port_b #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) u_dly (
        .clk(clk), .rst(rst), .enb(enb), .addrb(addrb), .web(web), .dib(dib),
        .rdyb(rdy_w[0]), .ackb(ack_w[0]), .dob(dob_w[0]), .errb(err_w[0])
    );

    dmem_port_b #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_fast (
        .clk(clk), .rst(rst), .enb(enb), .addrb(addrb), .web(web), .dib(dib),
        .rdyb(rdy_w[1]), .ackb(ack_w[1]), .dob(dob_w[1]), .errb(err_w[1])
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;
    int cyc = 0;

    // request-level model state
    int          wcyc [2] = '{1, 0};
    bit          pend [2] = '{1'b0, 1'b0};
    int          resp_cyc [2];
    logic [29:0] m_idx [2];
    logic [3:0]  m_web [2];
    logic [31:0] m_dib [2];
    logic        m_err [2];
    logic [31:0] m_dob [2];
    logic [31:0] mem_m [longint];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic longint key(input int k, input logic [29:0] idx);
        return (longint'(k) << 32) | longint'(idx);
    endfunction

    task automatic apply(input int k);
        longint      kk;
        logic [31:0] word;
        kk = key(k, m_idx[k]);
        m_err[k] = (m_idx[k] >= DEPTH);
        m_dob[k] = 32'd0;
        if (!m_err[k]) begin
            word = mem_m.exists(kk) ? mem_m[kk] : 32'hxxxxxxxx;
            if (m_web[k] == 4'b0000) begin
                m_dob[k] = word;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (m_web[k][i]) word[i*8 +: 8] = m_dib[k][i*8 +: 8];
                end
                mem_m[kk] = word;
            end
        end
    endtask

    // Model: accepted in cycle c -> response in cycle c+1+W; memory effect
    // lands on the edge just before the response unless reset intervenes.
    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                pend[k] = 1'b0;
            end else if (!pend[k]) begin
                if (enb) begin
                    pend[k]     = 1'b1;
                    resp_cyc[k] = cyc + 1 + wcyc[k];
                    m_idx[k]    = addrb[31:2];
                    m_web[k]    = web;
                    m_dib[k]    = dib;
                end
            end else if (cyc == resp_cyc[k]) begin
                pend[k] = 1'b0;
            end
            if (!rst && pend[k] && cyc == resp_cyc[k] - 1) apply(k);
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                logic exp_ack;
                exp_ack = pend[k] && (cyc == resp_cyc[k]);
                check($sformatf("model_rdyb[%0d]@%0d", k, cyc), rdy_w[k], !pend[k]);
                check($sformatf("model_ackb[%0d]@%0d", k, cyc), ack_w[k], exp_ack);
                if (exp_ack) begin
                    check($sformatf("model_errb[%0d]@%0d", k, cyc), err_w[k], m_err[k]);
                    check($sformatf("model_dob[%0d]@%0d", k, cyc), dob_w[k], m_dob[k]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        enb = 1'b1; addrb = a; web = w; dib = d;
        tick();
        enb = 1'b0; web = 4'd0; dib = 32'd0;
    endtask

    // One request with literal latency/data checks on both instances.
    task automatic lat_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                           input logic [31:0] dob_dly, input logic [31:0] dob_fast,
                           input logic err, input string tag);
        issue(a, w, d);
        @(negedge clk);
        check({tag, "_fast_ack_n1"}, ack_w[1], 1'b1);
        check({tag, "_fast_err"}, err_w[1], err);
        check({tag, "_fast_dob"}, dob_w[1], dob_fast);
        check({tag, "_dly_noack_n1"}, ack_w[0], 1'b0);
        tick();
        @(negedge clk);
        check({tag, "_dly_ack_n2"}, ack_w[0], 1'b1);
        check({tag, "_dly_err"}, err_w[0], err);
        check({tag, "_dly_dob"}, dob_w[0], dob_dly);
        tick();
    endtask

    initial begin
        int n_dly, n_fast;
        rst = 1'b1;
        tick();
        tick();
        enb = 1'b1; addrb = 32'h10; web = 4'd0;
        tick();
        rst = 1'b0; enb = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check("reset_rdyb_dly", rdy_w[0], 1'b1);
        check("reset_rdyb_fast", rdy_w[1], 1'b1);
        check("reset_ackb_dly", ack_w[0], 1'b0);
        check("reset_errb_dly", err_w[0], 1'b0);
        check("reset_dob_dly", dob_w[0], 32'd0);
        tick();
        @(negedge clk);
        check("rst_priority_noack", ack_w[0], 1'b0);
        tick();

        lat_req(32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0, "wr_full");
        lat_req(32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "rd_full");
        lat_req(32'h11, 4'b0010, 32'h0000AA00, 32'd0, 32'd0, 1'b0, "wr_byte");
        lat_req(32'h10, 4'h0, 32'd0, 32'hDEADAAEF, 32'hDEADAAEF, 1'b0, "rd_byte");
        lat_req(32'h13, 4'b1001, 32'h55000066, 32'd0, 32'd0, 1'b0, "wr_lanes03");
        lat_req(32'h10, 4'h0, 32'd0, 32'h55ADAA66, 32'h55ADAA66, 1'b0, "rd_lanes03");
        lat_req(32'h0, 4'hF, 32'h11223344, 32'd0, 32'd0, 1'b0, "wr_w0");
        lat_req(32'h00001000, 4'hF, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1, "wr_oor");
        lat_req(32'h0, 4'h0, 32'd0, 32'h11223344, 32'h11223344, 1'b0, "rd_w0");
        lat_req(32'h40000008, 4'h0, 32'd0, 32'd0, 32'd0, 1'b1, "rd_oor");
        lat_req(32'h20, 4'hF, 32'hCAFE0001, 32'd0, 32'd0, 1'b0, "wr_prior");

        // enb held high: one ack per W+2 cycles, extra requests dropped
        n_dly = 0; n_fast = 0;
        enb = 1'b1; addrb = 32'h10; web = 4'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack_w[0]) n_dly++;
            if (ack_w[1]) n_fast++;
            tick();
        end
        enb = 1'b0;
        check("burst_acks_dly", 32'(n_dly), 32'd4);
        check("burst_acks_fast", 32'(n_fast), 32'd6);
        tick();
        tick();

        // reset during the wait cycle aborts the write on the delayed instance
        issue(32'h20, 4'hF, 32'h12345678);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_ack_dly", ack_w[0], 1'b0);
        tick();
        lat_req(32'h20, 4'h0, 32'd0, 32'hCAFE0001, 32'h12345678, 1'b0, "rd_after_abort");

        // zero wait: ack in N+1, next request accepted in N+2
        issue(32'h10, 4'h0, 32'd0);
        @(negedge clk);
        check("fast_ack_n1", ack_w[1], 1'b1);
        check("fast_rdy_low_n1", rdy_w[1], 1'b0);
        tick();
        enb = 1'b1; addrb = 32'h0; web = 4'd0;
        @(negedge clk);
        check("fast_rdy_n2", rdy_w[1], 1'b1);
        tick();
        enb = 1'b0;
        @(negedge clk);
        check("fast_next_ack_n3", ack_w[1], 1'b1);
        check("fast_next_dob_n3", dob_w[1], 32'h11223344);
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_b.md
DMEM_PORT_B -- requirements
Module: dmem_port_b

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words stored; legal range 2..65536, power of two.
REQ-002 Parameter WAIT_CYCLES, default 1, meaning extra cycles between request acceptance and response; legal range 0..15.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 Port enb  input  1  request valid from the load/store side.
REQ-006 Port addrb  input  32  byte address of the request; bits [1:0] are ignored.
REQ-007 Port web  input  4  byte write enables, bit i writes byte lane i; 4'b0000 means read.
REQ-008 Port dib  input  32  write data, already lane-aligned by the requester.
REQ-009 Port rdyb  output  1  high when a request can be accepted this cycle.
REQ-010 Port ackb  output  1  one-cycle pulse marking response completion.
REQ-011 Port dob  output  32  full read word, valid only while ackb is high.
REQ-012 Port errb  output  1  high with ackb when the request address was out of range.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; transitions occur only on clk edges.
REQ-014 Acceptance: a request is accepted when enb is high and rdyb is high; accepted addrb, web and dib are captured in registers.
REQ-015 rdyb is high only in IDLE; enb in WAIT or RESP is ignored, with no queueing and no side effects.
REQ-016 IDLE to WAIT on acceptance when WAIT_CYCLES>0, loading the wait counter with WAIT_CYCLES-1; IDLE to RESP directly when WAIT_CYCLES=0.
REQ-017 In WAIT the counter decrements each cycle; at counter 0 the FSM moves to RESP.
REQ-018 Memory access happens on the edge entering RESP; word index = captured addrb[31:2].
REQ-019 Write (web != 0): only lanes with web[i]=1 are updated, other lanes are preserved; dob = 0 during ackb.
REQ-020 Read (web = 0): dob = the stored word at the index, unshifted; memory is unchanged.
REQ-021 Range: index >= DEPTH_WORDS sets errb=1 with ackb; no write occurs and dob=0.
REQ-022 RESP lasts exactly one cycle with ackb=1, then returns to IDLE; rdyb rises in the cycle after ackb.
REQ-023 Latency: enb accepted in cycle N gives ackb in cycle N+1+WAIT_CYCLES.
REQ-024 Back-to-back: a new request is accepted in the first IDLE cycle after RESP; throughput is one request per WAIT_CYCLES+2 cycles.
REQ-025 Outputs are registered; none depend combinationally on enb, addrb, web or dib.

Reset
REQ-026 On rst, the FSM goes to IDLE, the wait counter to 0, ackb=0, errb=0, dob=0, and rdyb=1 in the cycle after rst deasserts.
REQ-027 rst asserted in WAIT or RESP aborts the request: no write is performed if the RESP edge has not occurred, and no ackb is issued.
REQ-028 Memory contents are not cleared by rst.
REQ-029 rst has priority over enb in the same cycle; that request is not accepted.

Structure
REQ-030 The shared package holds the FSM state encoding, the web read code 4'b0000, and the default DEPTH_WORDS and WAIT_CYCLES.
REQ-031 One sub-module, dmem_bytelane_ram: a synchronous 4-lane byte-write RAM with a single port; the FSM and counters stay in dmem_port_b.

Verification
REQ-032 WAIT_CYCLES=1: write addrb=0x10, web=4'b1111, dib=0xDEADBEEF -> ackb in cycle N+2, errb=0; then read of 0x10 -> dob=0xDEADBEEF.
REQ-033 Byte write to the same word: addrb=0x11, web=4'b0010, dib=0x0000AA00 -> subsequent read of 0x10 returns 0xDEADAAEF.
REQ-034 enb held high continuously for reads of 0x10 -> ackb every 3 cycles; requests during WAIT/RESP are dropped and rdyb stays low.
REQ-035 DEPTH_WORDS=1024: write to addrb=0x00001000 -> ackb=1 with errb=1 and dob=0; read of word 0 is unchanged.
REQ-036 rst pulsed in WAIT during a write of 0x12345678 to 0x20 -> no ackb, and a later read of 0x20 returns the prior value.
REQ-037 WAIT_CYCLES=0: read accepted in cycle N -> ackb in cycle N+1; next request is accepted in cycle N+2.
